// File: rtl/latch_bank_ctrl_pkg.sv
// Shared definitions for the latch bank controller: FSM encoding and a width helper.
package latch_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ENABLE = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  // Never returns less than 1 so single-entry parameters still get a real vector.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/latch_bank_ctrl_if.sv
// Requester-side bus and latch-bank drive signals of the latch bank controller.
interface latch_bank_ctrl_if
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
);

  localparam int AW = clog2(DEPTH);

  // Handshake: a requester raises req[i] with stable addr/wdata and holds it until
  // ack[i]; gnt[i] marks capture of addr/wdata, ack[i] marks completion of the write.
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    addr;
  logic [NREQ*WIDTH-1:0] wdata;
  logic                  clr;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic                  err;
  logic                  busy;
  logic [DEPTH-1:0]      lat_en;
  logic [WIDTH-1:0]      lat_d;
  logic                  lat_rst;

  modport master (
    output req, addr, wdata, clr,
    input  gnt, ack, err, busy, lat_en, lat_d, lat_rst
  );

  modport slave (
    input  req, addr, wdata, clr,
    output gnt, ack, err, busy, lat_en, lat_d, lat_rst
  );

endinterface

// File: rtl/latch_bank_ctrl_rr_arbiter.sv
// Stateless round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]        req,
  input  logic [clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]        pick,
  output logic                   valid
);

  localparam int IW = clog2(NREQ);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IW'((int'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/latch_bank_ctrl.sv
// Sequences arbitrated writes into a bank of level-sensitive latch words with
// setup/enable/hold framing of the one-hot enables and a bank-wide clear.
module latch_bank_ctrl
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 8,
  parameter int EN_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  latch_bank_ctrl_if.slave   bus,
  output logic [STATE_W-1:0] dbg_state
);

  localparam int AW = clog2(DEPTH);
  localparam int IW = clog2(NREQ);
  localparam int CW = clog2(EN_CYCLES);

  state_t            state, state_n;
  logic [IW-1:0]     rr_ptr, rr_ptr_n;
  logic [IW-1:0]     winner, winner_n;
  logic [AW-1:0]     caddr, caddr_n;
  logic [CW-1:0]     en_cnt, en_cnt_n;
  logic              clr_pend, clr_pend_n;
  logic              boot;

  logic [NREQ-1:0]   gnt_q, gnt_n;
  logic [NREQ-1:0]   ack_q, ack_n;
  logic              err_q, err_n;
  logic              busy_q, busy_n;
  logic [DEPTH-1:0]  lat_en_q, lat_en_n;
  logic [WIDTH-1:0]  lat_d_q, lat_d_n;
  logic              lat_rst_q, lat_rst_n;

  logic [NREQ-1:0]   pick;
  logic              pick_valid;
  logic [IW-1:0]     pick_idx;
  logic [AW-1:0]     sel_addr;
  logic [WIDTH-1:0]  sel_data;
  logic [DEPTH-1:0]  addr_dec;
  logic              addr_bad;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (bus.req),
    .ptr   (rr_ptr),
    .pick  (pick),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_idx = IW'(i);
    end
  end

  assign sel_addr = bus.addr[int'(pick_idx)*AW +: AW];
  assign sel_data = bus.wdata[int'(pick_idx)*WIDTH +: WIDTH];

  // Out-of-range addresses decode to no enable at all.
  always_comb begin
    addr_dec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      addr_dec[i] = (caddr == AW'(i));
    end
  end

  assign addr_bad = (int'(caddr) >= DEPTH);

  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    winner_n   = winner;
    caddr_n    = caddr;
    en_cnt_n   = en_cnt;
    clr_pend_n = clr_pend;
    gnt_n      = '0;
    ack_n      = '0;
    err_n      = 1'b0;
    lat_en_n   = '0;
    lat_d_n    = lat_d_q;
    lat_rst_n  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (boot) begin
          // First cycle out of reset keeps the bank cleared; no grant yet.
          lat_rst_n  = 1'b1;
          clr_pend_n = clr_pend | bus.clr;
        end else if (bus.clr || clr_pend) begin
          state_n   = ST_CLEAR;
          lat_rst_n = 1'b1;
        end else if (pick_valid) begin
          state_n  = ST_SETUP;
          gnt_n    = pick;
          winner_n = pick_idx;
          caddr_n  = sel_addr;
          lat_d_n  = sel_data;
        end
      end
      ST_CLEAR: begin
        state_n    = ST_IDLE;
        clr_pend_n = 1'b0;
      end
      ST_SETUP: begin
        state_n    = ST_ENABLE;
        lat_en_n   = addr_dec;
        en_cnt_n   = CW'(EN_CYCLES - 1);
        clr_pend_n = clr_pend | bus.clr;
      end
      ST_ENABLE: begin
        clr_pend_n = clr_pend | bus.clr;
        if (en_cnt == '0) begin
          state_n       = ST_HOLD;
          ack_n[winner] = 1'b1;
          err_n         = addr_bad;
        end else begin
          en_cnt_n = en_cnt - 1'b1;
          lat_en_n = lat_en_q;
        end
      end
      ST_HOLD: begin
        state_n    = ST_IDLE;
        rr_ptr_n   = (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
        clr_pend_n = clr_pend | bus.clr;
      end
      default: state_n = ST_IDLE;
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      winner    <= '0;
      caddr     <= '0;
      en_cnt    <= '0;
      clr_pend  <= 1'b0;
      boot      <= 1'b1;
      gnt_q     <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      lat_en_q  <= '0;
      lat_d_q   <= '0;
      lat_rst_q <= 1'b1;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      winner    <= winner_n;
      caddr     <= caddr_n;
      en_cnt    <= en_cnt_n;
      clr_pend  <= clr_pend_n;
      boot      <= 1'b0;
      gnt_q     <= gnt_n;
      ack_q     <= ack_n;
      err_q     <= err_n;
      busy_q    <= busy_n;
      lat_en_q  <= lat_en_n;
      lat_d_q   <= lat_d_n;
      lat_rst_q <= lat_rst_n;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.ack     = ack_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;
  assign bus.lat_en  = lat_en_q;
  assign bus.lat_d   = lat_d_q;
  assign bus.lat_rst = lat_rst_q;
  assign dbg_state   = state;

endmodule
